// File: rtl/decode_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_stage_pkg: imm_sel encodings, RV32I opcodes, NOP and entry type |
// | Optional: DECODE_ILLEGAL_EN adds a per-entry illegal flag. Rev 1.0    |
// +----------------------------------------------------------------------+
package decode_stage_pkg;

   localparam logic [4:0] c_imm_r      = 5'd0;
   localparam logic [4:0] c_imm_s      = 5'd1;
   localparam logic [4:0] c_imm_b      = 5'd2;
   localparam logic [4:0] c_imm_u      = 5'd3;
   localparam logic [4:0] c_imm_j      = 5'd4;
   localparam logic [4:0] c_imm_i      = 5'd5;
   localparam logic [4:0] c_imm_i_star = 5'd6;

   localparam logic [6:0] c_op_op     = 7'b0110011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_lui    = 7'b0110111;
   localparam logic [6:0] c_op_auipc  = 7'b0010111;
   localparam logic [6:0] c_op_jal    = 7'b1101111;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;
   localparam logic [6:0] c_op_op_imm = 7'b0010011;
   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_system = 7'b1110011;

   localparam logic [31:0] c_nop_inst = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [4:0]  imm_sel;
`ifdef DECODE_ILLEGAL_EN
      logic        illegal;
`endif
   } entry_t;

endpackage
`default_nettype wire

// File: rtl/decode_stage_imm_sel_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_sel_decode: opcode/funct3 to immediate type (and illegal flag)    |
// | Optional: DECODE_ILLEGAL_EN adds o_illegal.                Rev 1.0    |
// +----------------------------------------------------------------------+
module imm_sel_decode
   import decode_stage_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   output logic [4:0] o_imm_sel
`ifdef DECODE_ILLEGAL_EN
   ,
   output logic       o_illegal
`endif
);

   always_comb begin
      o_imm_sel = c_imm_r;
      case (i_opcode)
         c_op_op:                       o_imm_sel = c_imm_r;
         c_op_store:                    o_imm_sel = c_imm_s;
         c_op_branch:                   o_imm_sel = c_imm_b;
         c_op_lui, c_op_auipc:          o_imm_sel = c_imm_u;
         c_op_jal:                      o_imm_sel = c_imm_j;
         // shift-immediates carry a shamt, not a sign-extended imm
         c_op_op_imm:                   o_imm_sel = (i_funct3 == 3'b001 || i_funct3 == 3'b101)
                                                    ? c_imm_i_star : c_imm_i;
         c_op_load, c_op_jalr, c_op_system: o_imm_sel = c_imm_i;
         default:                       o_imm_sel = c_imm_r;
      endcase
   end

`ifdef DECODE_ILLEGAL_EN
   logic w_unknown;

   always_comb begin
      w_unknown = 1'b1;
      case (i_opcode)
         c_op_op, c_op_store, c_op_branch, c_op_lui, c_op_auipc, c_op_jal,
         c_op_op_imm, c_op_load, c_op_jalr, c_op_system: w_unknown = 1'b0;
         default:                                         w_unknown = 1'b1;
      endcase
   end

   assign o_illegal = w_unknown | (i_opcode[1:0] != 2'b11);
`endif

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_stage: IF/ID register, 2-entry skid buffer, imm_sel predecode  |
// | Optional: DECODE_ILLEGAL_EN adds out_illegal.              Rev 1.0    |
// +----------------------------------------------------------------------+
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_2000,
   parameter logic [31:0] NOP_INST = c_nop_inst
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_pc,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic [4:0]  out_imm_sel,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd
`ifdef DECODE_ILLEGAL_EN
   ,
   output logic        out_illegal
`endif
);

   // bit0 = main valid, bit1 = skid valid
   localparam logic [1:0] c_empty = 2'b00;
   localparam logic [1:0] c_one   = 2'b01;
   localparam logic [1:0] c_full  = 2'b11;

   logic [1:0] r_state;
   entry_t     r_main;
   entry_t     r_skid;
   entry_t     w_in_entry;
   logic [4:0] w_dec_sel;
   logic       w_accept;
   logic       w_consume;

   imm_sel_decode u_imm_sel_decode (
      .i_opcode  (in_inst[6:0]),
      .i_funct3  (in_inst[14:12]),
      .o_imm_sel (w_dec_sel)
`ifdef DECODE_ILLEGAL_EN
      ,
      .o_illegal (w_in_entry.illegal)
`endif
   );

   assign w_in_entry.inst    = in_inst;
   assign w_in_entry.pc      = in_pc;
   assign w_in_entry.imm_sel = w_dec_sel;

   assign in_ready  = ~r_state[1];
   assign out_valid = r_state[0];
   assign w_accept  = in_valid & in_ready;
   assign w_consume = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_empty;
         r_main  <= '0;
         r_skid  <= '0;
      end else if (flush) begin
         r_state <= c_empty;
      end else begin
         case (r_state)
            c_empty: begin
               if (w_accept) begin
                  r_state <= c_one;
                  r_main  <= w_in_entry;
               end
            end
            c_one: begin
               if (w_accept && w_consume) begin
                  r_main  <= w_in_entry;
               end else if (w_accept) begin
                  r_state <= c_full;
                  r_skid  <= w_in_entry;
               end else if (w_consume) begin
                  r_state <= c_empty;
               end
            end
            c_full: begin
               if (w_consume) begin
                  r_state <= c_one;
                  r_main  <= r_skid;
               end
            end
            default: r_state <= c_empty;
         endcase
      end
   end

   always_comb begin
      out_inst    = NOP_INST;
      out_pc      = PC_RESET;
      out_imm_sel = c_imm_i;
      out_rs1     = 5'd0;
      out_rs2     = 5'd0;
      out_rd      = 5'd0;
`ifdef DECODE_ILLEGAL_EN
      out_illegal = 1'b0;
`endif
      if (out_valid) begin
         out_inst    = r_main.inst;
         out_pc      = r_main.pc;
         out_imm_sel = r_main.imm_sel;
         out_rs1     = r_main.inst[19:15];
         out_rs2     = r_main.inst[24:20];
         out_rd      = r_main.inst[11:7];
`ifdef DECODE_ILLEGAL_EN
         out_illegal = r_main.illegal;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_decode_stage: directed vectors with queued expectations            |
// | Optional: DECODE_ILLEGAL_EN checks out_illegal.            Rev 1.0    |
// +----------------------------------------------------------------------+
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [4:0]  out_imm_sel;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
`ifdef DECODE_ILLEGAL_EN
   logic        out_illegal;
`endif

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [4:0]  sel;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   decode_stage dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_pc       (in_pc),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_inst    (out_inst),
      .out_pc      (out_pc),
      .out_imm_sel (out_imm_sel),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_rd      (out_rd)
`ifdef DECODE_ILLEGAL_EN
      ,
      .out_illegal (out_illegal)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [31:0] inst, input logic [31:0] pc,
                           input logic [4:0] sel, input logic ill);
      exp_t e;
      e.inst = inst;
      e.pc   = pc;
      e.sel  = sel;
      e.ill  = ill;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
      in_valid = v;
      in_inst  = inst;
      in_pc    = pc;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every consumed head must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%h required=none", out_inst);
         end else begin
            e = exp_q.pop_front();
            check("sb_inst", out_inst, e.inst);
            check("sb_pc", out_pc, e.pc);
            check("sb_imm_sel", {27'd0, out_imm_sel}, {27'd0, e.sel});
            check("sb_rs1", {27'd0, out_rs1}, {27'd0, e.inst[19:15]});
            check("sb_rs2", {27'd0, out_rs2}, {27'd0, e.inst[24:20]});
            check("sb_rd", {27'd0, out_rd}, {27'd0, e.inst[11:7]});
`ifdef DECODE_ILLEGAL_EN
            check("sb_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   logic [31:0] s_inst [4];
   logic [4:0]  s_sel  [4];

   initial begin
      s_inst = '{32'h00A00093, 32'h00209113, 32'hFE000EE3, 32'h0000006F};
      s_sel  = '{5'd5, 5'd6, 5'd2, 5'd4};
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      #12 rst = 1'b0;

      // reset / idle state
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_inst", out_inst, 32'h0000_0013);
      check("rst_out_pc", out_pc, 32'h0000_2000);
      check("rst_imm_sel", {27'd0, out_imm_sel}, 32'd5);
      check("rst_regs", {17'd0, out_rs1, out_rs2, out_rd}, 32'd0);
`ifdef DECODE_ILLEGAL_EN
      check("rst_illegal", {31'd0, out_illegal}, 32'd0);
`endif

      // back-to-back stream, one per cycle
      cyc();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, s_inst[i], 32'h2000 + 32'(4 * i));
         push_exp(s_inst[i], 32'h2000 + 32'(4 * i), s_sel[i], 1'b0);
         @(negedge clk);
         check("stream_in_ready", {31'd0, in_ready}, 32'd1);
         check("stream_latency", {31'd0, out_valid}, (i == 0) ? 32'd0 : 32'd1);
         cyc();
      end
      drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      cyc();
      out_ready = 1'b0;
      @(negedge clk);
      check("stream_drained", {31'd0, out_valid}, 32'd0);

      // backpressure: sw then lui with out_ready low
      cyc();
      drive(1'b1, 32'h00112223, 32'h3000);
      push_exp(32'h00112223, 32'h3000, 5'd1, 1'b0);
      cyc();
      drive(1'b1, 32'h123450B7, 32'h3004);
      push_exp(32'h123450B7, 32'h3004, 5'd3, 1'b0);
      @(negedge clk);
      check("bp_in_ready_one", {31'd0, in_ready}, 32'd1);
      check("bp_sel_sw", {27'd0, out_imm_sel}, 32'd1);
      cyc();
      drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
      check("bp_hold_inst", out_inst, 32'h00112223);
      check("bp_hold_sel", {27'd0, out_imm_sel}, 32'd1);
      cyc();
      @(negedge clk);
      check("bp_hold_inst2", out_inst, 32'h00112223);
      check("bp_hold_pc2", out_pc, 32'h3000);
      cyc();
      out_ready = 1'b1;
      @(negedge clk);
      cyc();
      @(negedge clk);
      check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
      check("bp_sel_lui", {27'd0, out_imm_sel}, 32'd3);
      cyc();
      out_ready = 1'b0;

      // fill to FULL, then flush with in_valid high
      drive(1'b1, 32'h00A00093, 32'h4000);
      cyc();
      drive(1'b1, 32'h00112223, 32'h4004);
      cyc();
      drive(1'b1, 32'h0000006F, 32'h4008);
      flush = 1'b1;
      @(negedge clk);
      check("fl_full_in_ready", {31'd0, in_ready}, 32'd0);
      check("fl_full_head", out_inst, 32'h00A00093);
      cyc();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("fl_out_valid", {31'd0, out_valid}, 32'd0);
      check("fl_in_ready", {31'd0, in_ready}, 32'd1);
      check("fl_out_inst", out_inst, 32'h0000_0013);
      check("fl_out_pc", out_pc, 32'h0000_2000);

      // flush while EMPTY drops the same-cycle handshake
      cyc();
      drive(1'b1, 32'h123450B7, 32'h5000);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 32'h00A00093, 32'h5004);
      push_exp(32'h00A00093, 32'h5004, 5'd5, 1'b0);
      @(negedge clk);
      check("fle_out_valid", {31'd0, out_valid}, 32'd0);
      cyc();
      drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);

      // async reset mid-stream
      cyc();
      out_ready = 1'b0;
      drive(1'b1, 32'h00112223, 32'h6000);
      cyc();
      drive(1'b1, 32'hFE000EE3, 32'h6004);
      @(negedge clk);
      check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("ar_out_valid", {31'd0, out_valid}, 32'd0);
      check("ar_in_ready", {31'd0, in_ready}, 32'd1);
      check("ar_out_pc", out_pc, 32'h0000_2000);
      drive(1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 32'h0000006F, 32'h7000);
      push_exp(32'h0000006F, 32'h7000, 5'd4, 1'b0);
      @(negedge clk);
      check("ar_lat0", {31'd0, out_valid}, 32'd0);
      cyc();
      drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("ar_lat1", {31'd0, out_valid}, 32'd1);

      // unknown opcode decodes to imm_sel 0 (and flags illegal when enabled)
      cyc();
      drive(1'b1, 32'h0000007F, 32'h8000);
      push_exp(32'h0000007F, 32'h8000, 5'd0, 1'b1);
      cyc();
      drive(1'b1, 32'h00A00093, 32'h8004);
      push_exp(32'h00A00093, 32'h8004, 5'd5, 1'b0);
      cyc();
      drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      cyc();
      @(negedge clk);
      check("end_out_valid", {31'd0, out_valid}, 32'd0);
      check("end_queue_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- IF/ID boundary register with integrated immediate-select decode.
- Accepts fetched instruction/PC over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Presents registered inst, pc, register indices and a 5-bit imm_sel to the immediate generator and execute logic.
- Supports pipeline flush on branch/jump redirect.

Parameters:
- PC_RESET, 32'h0000_2000, out_pc value while empty or after reset.
- NOP_INST, 32'h0000_0013, instruction driven on out_inst when no valid entry (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept; registered, equals !skid_valid
- in_inst  input  32  fetched instruction
- in_pc  input  32  PC of in_inst
- flush  input  1  discard all held and incoming instructions
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream consumes head this cycle
- out_inst  output  32  head instruction (feeds immGen inst)
- out_pc  output  32  head PC
- out_imm_sel  output  5  immediate type (feeds immGen imm_sel)
- out_rs1, out_rs2, out_rd  output  5 each  inst[19:15], inst[24:20], inst[11:7] of head

Behaviour:
- Reset (async, immediate): all entries invalid; out_valid=0, in_ready=1, out_inst=NOP_INST, out_pc=PC_RESET, out_imm_sel=5, out_rs1/rs2/rd=0.
- imm_sel decode is performed on in_inst before storage, so the stored entry holds {inst, pc, imm_sel}. Mapping on opcode inst[6:0]:
  - 0110011 -> 0 (R)
  - 0100011 -> 1 (S)
  - 1100011 -> 2 (B)
  - 0110111 and 0010111 -> 3 (U)
  - 1101111 -> 4 (J)
  - 0010011 with funct3 001 or 101 -> 6 (I_star, shamt)
  - 0010011 other funct3, 0000011, 1100111, 1110011 -> 5 (I)
  - any other opcode -> 0
  - imm_sel bits [4:3] always 0.
- Handshake:
  - Accept occurs when in_valid & in_ready.
  - Consume occurs when out_valid & out_ready.
  - Latency is 1 cycle from accept to out_valid.
- State machine, over entries main (head) and skid:
  - EMPTY: accept -> ONE, main loaded.
  - ONE:
    - accept & consume -> ONE, main reloaded.
    - accept & !consume -> FULL, skid loaded.
    - consume only -> EMPTY.
    - neither -> ONE.
  - FULL (in_ready=0):
    - consume -> ONE, skid moves to main.
    - otherwise hold.
- Outputs are a function of main only. When main is invalid, outputs show the reset values (NOP/PC_RESET/imm_sel 5).
- Held outputs stay stable while out_valid & !out_ready.
- flush has highest priority:
  - next state EMPTY; both entries invalidated.
  - An instruction handshaked in the flush cycle is dropped.
  - A consume in the flush cycle is still legal downstream.
  - in_ready=1 the cycle after flush.
- flush asserted while EMPTY: no effect beyond dropping the same-cycle input.
- Back-to-back throughput is one instruction per cycle with out_ready held high.
- Reset asserted mid-operation discards all entries asynchronously; the first accept is possible in the cycle after rst deasserts.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- Defined:
  - Adds output port out_illegal (1 bit).
  - out_illegal is stored per entry and is 1 when the head opcode is not in the mapping list, or inst[1:0]!=2'b11.
  - It is 0 when the head is invalid and resets to 0.
  - imm_sel for illegal instructions stays 0.
- Undefined: port absent; unknown opcodes silently decode to imm_sel 0.

Decomposition:
- Shared package/header holds:
  - imm_sel encodings (R=0, S=1, B=2, U=3, J=4, I=5, I_STAR=6), shared with the immediate generator.
  - RV32I opcode constants.
  - NOP_INST.
- One sub-module, imm_sel_decode: combinational opcode/funct3 to imm_sel (and illegal flag), instantiated once on the input side.
- Skid control stays in decode_stage.

Test Plan:
- Reset then idle -> out_valid=0, out_inst=32'h00000013, out_pc=32'h2000, out_imm_sel=5, in_ready=1.
- Stream 32'h00A00093 (addi), 32'h00209113 (slli), 32'hFE000EE3 (beq), 32'h0000006F (jal) at pc 0x2000..0x200C with out_ready=1 -> one per cycle, imm_sel 5,6,2,4, pcs in order, 1-cycle latency.
- Accept sw 32'h00112223 then lui 32'h123450B7 with out_ready=0 -> in_ready falls to 0; out_imm_sel=1 held stable; raise out_ready -> lui presented next cycle with imm_sel 3; in_ready returns to 1.
- FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears at the output.
- Assert rst asynchronously mid-stream, between clock edges -> out_valid drops immediately; after release the first new instruction appears one cycle after accept.
- With DECODE_ILLEGAL_EN: inst 32'h0000007F -> out_illegal=1, imm_sel=0; following addi -> out_illegal=0.
